// File: rtl/flp_normshl_if.sv
// Handshake and data bundle for the left normalizer: operand side (i_*) in,
// result side (o_*) out, each with its own valid/ready pair.
interface flp_normshl_if #(
    parameter int WIDTH  = 32,
    parameter int EWIDTH = 10
);
    logic              i_vld;
    logic              o_rdy;
    logic [WIDTH-1:0]  i_mant;
    logic [EWIDTH-1:0] i_exp;
    logic              o_vld;
    logic              i_rdy;
    logic [WIDTH-1:0]  o_mant;
    logic [EWIDTH-1:0] o_exp;
    logic              o_zero;
    logic              o_denorm;

    modport master (
        output i_vld, i_mant, i_exp, i_rdy,
        input  o_rdy, o_vld, o_mant, o_exp, o_zero, o_denorm
    );

    modport slave (
        input  i_vld, i_mant, i_exp, i_rdy,
        output o_rdy, o_vld, o_mant, o_exp, o_zero, o_denorm
    );
endinterface

// File: rtl/flp_normshl.sv
// Multi-cycle left normalizer: shifts the mantissa left (coarse STEP or single bit
// per clock) until its MSB is set or the exponent reaches the minimum normal value.
module flp_normshl #(
    parameter int WIDTH  = 32,
    parameter int EWIDTH = 10,
    parameter int STEP   = 4
) (
    input logic           clk,
    input logic           nrst,
    flp_normshl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [EWIDTH-1:0] EXP_STEP  = EWIDTH'(STEP);
    localparam logic [EWIDTH-1:0] EXP_COARSE = EWIDTH'(STEP + 1);
    localparam logic [EWIDTH-1:0] EXP_ONE   = EWIDTH'(1);

    state_t            state;
    state_t            nextState;
    logic [WIDTH-1:0]  workMant;
    logic [EWIDTH-1:0] workExp;
    logic [WIDTH-1:0]  resMant;
    logic [EWIDTH-1:0] resExp;
    logic              resZero;
    logic              resDenorm;

    logic              earlyDone;
    logic              coarse;
    logic [WIDTH-1:0]  shMant;
    logic [EWIDTH-1:0] shExp;
    logic              shiftDone;

    // Operands that are zero, denormal, already at the exponent floor, or already
    // normalized skip the SHIFT state entirely.
    always_comb begin
        earlyDone = (bus.i_mant == '0) || (bus.i_exp <= EXP_ONE) || bus.i_mant[WIDTH-1];
        coarse    = (workMant[WIDTH-1 -: STEP] == '0) && (workExp >= EXP_COARSE);
        shMant    = coarse ? (workMant << STEP) : (workMant << 1);
        shExp     = coarse ? (workExp - EXP_STEP) : (workExp - EXP_ONE);
        shiftDone = shMant[WIDTH-1] || (shExp == EXP_ONE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.i_vld) nextState = earlyDone ? DONE : SHIFT;
            SHIFT:   if (shiftDone) nextState = DONE;
            DONE:    if (bus.i_rdy) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.o_rdy    = (state == IDLE);
        bus.o_vld    = (state == DONE);
        bus.o_mant   = resMant;
        bus.o_exp    = resExp;
        bus.o_zero   = resZero;
        bus.o_denorm = resDenorm;
    end

    // Result registers only load on the transition into DONE, so they stay
    // frozen for as long as the downstream stage stalls.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            workMant  <= '0;
            workExp   <= '0;
            resMant   <= '0;
            resExp    <= '0;
            resZero   <= 1'b0;
            resDenorm <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_vld) begin
                        workMant  <= bus.i_mant;
                        workExp   <= bus.i_exp;
                        resZero   <= 1'b0;
                        resDenorm <= 1'b0;
                        if (bus.i_mant == '0) begin
                            resMant <= '0;
                            resExp  <= '0;
                            resZero <= 1'b1;
                        end else if (bus.i_exp == '0) begin
                            resMant   <= bus.i_mant;
                            resExp    <= '0;
                            resDenorm <= 1'b1;
                        end else if (bus.i_exp == EXP_ONE && !bus.i_mant[WIDTH-1]) begin
                            resMant   <= bus.i_mant;
                            resExp    <= '0;
                            resDenorm <= 1'b1;
                        end else if (bus.i_mant[WIDTH-1]) begin
                            resMant <= bus.i_mant;
                            resExp  <= bus.i_exp;
                        end
                    end
                end
                SHIFT: begin
                    workMant <= shMant;
                    workExp  <= shExp;
                    if (shMant[WIDTH-1]) begin
                        resMant <= shMant;
                        resExp  <= shExp;
                    end else if (shExp == EXP_ONE) begin
                        resMant   <= shMant;
                        resExp    <= '0;
                        resDenorm <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_flp_normshl.sv
// Self-checking bench for flp_normshl: directed vectors, random operands against a
// leading-zero-count reference model, backpressure and mid-operation reset.
module tb_flp_normshl;
    localparam int W  = 32;
    localparam int E  = 10;
    localparam int ST = 4;

    logic clk;
    logic nrst;
    int   nChecks;
    int   nFails;

    flp_normshl_if #(.WIDTH(W), .EWIDTH(E)) bus ();

    flp_normshl #(.WIDTH(W), .EWIDTH(E), .STEP(ST)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: normalize by the leading-zero count, capped by the exponent floor;
    // the step count follows the greedy coarse/single schedule on plain integers.
    task automatic model(input logic [W-1:0] m, input logic [E-1:0] e,
                         output logic [W-1:0] em, output logic [E-1:0] ee,
                         output logic ez, output logic ed, output int s);
        int lz, amt, lzr, er;
        em = m; ee = e; ez = 1'b0; ed = 1'b0; s = 0;
        if (m == '0) begin
            em = '0; ee = '0; ez = 1'b1;
        end else if (e == '0) begin
            ed = 1'b1;
        end else begin
            lz = 0;
            while (m[W-1-lz] == 1'b0) lz++;
            amt = (lz < int'(e) - 1) ? lz : int'(e) - 1;
            em  = m << amt;
            if (amt == lz) ee = e - E'(lz);
            else begin ee = '0; ed = 1'b1; end
            lzr = lz;
            er  = int'(e);
            while (lzr > 0 && er > 1) begin
                if (lzr >= ST && er >= ST + 1) begin lzr -= ST; er -= ST; end
                else begin lzr--; er--; end
                s++;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic [E-1:0] e, input string name);
        logic [W-1:0] em; logic [E-1:0] ee; logic ez, ed; int s, cnt;
        model(m, e, em, ee, ez, ed, s);
        @(negedge clk);
        nChecks++;
        if (bus.o_rdy !== 1'b1) begin
            nFails++; $display("[TB] FAIL %s o_rdy before accept: got %b want 1", name, bus.o_rdy);
        end
        bus.i_vld = 1'b1; bus.i_mant = m; bus.i_exp = e; bus.i_rdy = 1'b0;
        @(posedge clk); #1;
        bus.i_vld = 1'b0;
        cnt = 0;
        while (bus.o_vld !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        nChecks++;
        if (cnt !== s) begin
            nFails++; $display("[TB] FAIL %s latency steps: got %0d want %0d", name, cnt, s);
        end
        nChecks++;
        if (bus.o_mant !== em || bus.o_exp !== ee || bus.o_zero !== ez || bus.o_denorm !== ed) begin
            nFails++;
            $display("[TB] FAIL %s result m=%h e=%0d: got mant %h exp %0d z %b d %b want mant %h exp %0d z %b d %b",
                     name, m, e, bus.o_mant, bus.o_exp, bus.o_zero, bus.o_denorm, em, ee, ez, ed);
        end
        @(negedge clk); bus.i_rdy = 1'b1;
        @(posedge clk); #1; bus.i_rdy = 1'b0;
        nChecks++;
        if (bus.o_vld !== 1'b0 || bus.o_rdy !== 1'b1) begin
            nFails++; $display("[TB] FAIL %s after handshake: got vld %b rdy %b want vld 0 rdy 1", name, bus.o_vld, bus.o_rdy);
        end
    endtask

    task automatic test_reset;
        bus.i_vld = 1'b0; bus.i_rdy = 1'b0; bus.i_mant = '0; bus.i_exp = '0;
        nrst = 1'b0;
        #12;
        nChecks++;
        if (bus.o_vld !== 1'b0 || bus.o_rdy !== 1'b1 || bus.o_mant !== '0 || bus.o_exp !== '0 ||
            bus.o_zero !== 1'b0 || bus.o_denorm !== 1'b0) begin
            nFails++; $display("[TB] FAIL reset values: got vld %b rdy %b mant %h exp %0d z %b d %b",
                               bus.o_vld, bus.o_rdy, bus.o_mant, bus.o_exp, bus.o_zero, bus.o_denorm);
        end
        @(negedge clk); nrst = 1'b1;
    endtask

    task automatic test_directed;
        run_op(32'h8000_0000, 10'd100, "already_normal");
        run_op(32'h0000_0001, 10'd200, "full_shift");
        run_op(32'h0000_0100, 10'd5,   "floor_denorm");
        run_op(32'h0000_0000, 10'd77,  "zero");
        run_op(32'h1234_5678, 10'd0,   "exp0_passthrough");
        run_op(32'h0000_0F00, 10'd1,   "exp1_denorm");
        run_op(32'h0800_0000, 10'd5,   "reach_exp1_normal");
        run_op(32'h0000_0003, 10'd3,   "single_steps_floor");
    endtask

    task automatic test_random;
        logic [W-1:0] m; logic [E-1:0] e;
        for (int i = 0; i < 40; i++) begin
            m = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) m = '0;
            e = ($urandom_range(0, 1) == 0) ? E'($urandom_range(0, 40)) : E'($urandom_range(0, 1023));
            run_op(m, e, "random");
        end
    endtask

    task automatic test_backpressure;
        int cnt;
        @(negedge clk);
        bus.i_vld = 1'b1; bus.i_mant = 32'h0000_0001; bus.i_exp = 10'd200; bus.i_rdy = 1'b0;
        @(posedge clk); #1;
        bus.i_mant = 32'h0000_00F0; bus.i_exp = 10'd50;
        cnt = 0;
        while (bus.o_vld !== 1'b1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
        for (int i = 0; i < 5; i++) begin
            nChecks++;
            if (bus.o_vld !== 1'b1 || bus.o_rdy !== 1'b0 || bus.o_mant !== 32'h8000_0000 || bus.o_exp !== 10'd169) begin
                nFails++; $display("[TB] FAIL stall hold cycle %0d: got vld %b rdy %b mant %h exp %0d want 1 0 80000000 169",
                                   i, bus.o_vld, bus.o_rdy, bus.o_mant, bus.o_exp);
            end
            @(posedge clk); #1;
        end
        @(negedge clk); bus.i_rdy = 1'b1;
        @(posedge clk); #1; bus.i_rdy = 1'b0;
        nChecks++;
        if (bus.o_rdy !== 1'b1 || bus.o_vld !== 1'b0) begin
            nFails++; $display("[TB] FAIL stall release: got rdy %b vld %b want 1 0", bus.o_rdy, bus.o_vld);
        end
        @(posedge clk); #1; bus.i_vld = 1'b0;
        cnt = 0;
        while (bus.o_vld !== 1'b1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
        nChecks++;
        if (bus.o_mant !== 32'hF000_0000 || bus.o_exp !== 10'd26 || cnt !== 6) begin
            nFails++; $display("[TB] FAIL stall next operand: got mant %h exp %0d steps %0d want f0000000 26 6",
                               bus.o_mant, bus.o_exp, cnt);
        end
        @(negedge clk); bus.i_rdy = 1'b1;
        @(posedge clk); #1; bus.i_rdy = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        @(negedge clk);
        bus.i_vld = 1'b1; bus.i_mant = 32'h0000_0001; bus.i_exp = 10'd200;
        @(posedge clk); #1; bus.i_vld = 1'b0;
        repeat (3) @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        nChecks++;
        if (bus.o_vld !== 1'b0 || bus.o_rdy !== 1'b1 || bus.o_mant !== '0 || bus.o_exp !== '0 ||
            bus.o_zero !== 1'b0 || bus.o_denorm !== 1'b0) begin
            nFails++; $display("[TB] FAIL mid-shift reset: got vld %b rdy %b mant %h exp %0d z %b d %b",
                               bus.o_vld, bus.o_rdy, bus.o_mant, bus.o_exp, bus.o_zero, bus.o_denorm);
        end
        @(negedge clk); nrst = 1'b1;
        run_op(32'h0000_00F0, 10'd50, "after_reset");
    endtask

    task automatic test_back_to_back;
        run_op(32'h4000_0000, 10'd2,   "b2b_a");
        run_op(32'h0001_0000, 10'd900, "b2b_b");
        run_op(32'h0000_0000, 10'd0,   "b2b_c");
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
